// File: rtl/usb2_ep_router_pkg.sv
// Shared definitions for the USB 2.0 endpoint router: FSM encoding, select
// width, drain timeout default and the data-toggle sequencing helper.
package usb2_ep_router_pkg;

   localparam int SEL_W         = 4;
   localparam int DRAIN_TMO_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_e;

   // Normal endpoints alternate DATA0/DATA1; high-bandwidth ones cycle 0,1,2.
   function automatic logic [1:0] next_toggle(input logic [1:0] cur, input logic hb);
      if (hb) return (cur >= 2'd2) ? 2'd0 : cur + 2'd1;
      return (cur == 2'd0) ? 2'd1 : 2'd0;
   endfunction

endpackage

// File: rtl/usb2_ep_router_if.sv
// Packet-layer side of the endpoint buffer handshakes. The packet layer is the
// master; the router is the slave and answers from the current endpoint.
interface usb2_ep_router_if #(
   parameter int ADDR_W = 9,
   parameter int LEN_W  = 10
);
   logic [ADDR_W-1:0] buf_in_addr;
   logic [7:0]        buf_in_data;
   logic              buf_in_wren;
   logic              buf_in_commit;
   logic [LEN_W-1:0]  buf_in_commit_len;
   logic              buf_in_ready;
   logic              buf_in_commit_ack;

   logic [ADDR_W-1:0] buf_out_addr;
   logic              buf_out_arm;
   logic [7:0]        buf_out_q;
   logic [LEN_W-1:0]  buf_out_len;
   logic              buf_out_hasdata;
   logic              buf_out_arm_ack;

   modport master (
      output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
      output buf_out_addr, buf_out_arm,
      input  buf_in_ready, buf_in_commit_ack,
      input  buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack
   );

   modport slave (
      input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
      input  buf_out_addr, buf_out_arm,
      output buf_in_ready, buf_in_commit_ack,
      output buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack
   );
endinterface

// File: rtl/usb2_ep_router_toggle_bank.sv
// Per-endpoint data-toggle and halt registers. Clears beat advances, and a
// halt request beats a halt release arriving in the same cycle.
module usb2_ep_router_toggle_bank
   import usb2_ep_router_pkg::*;
#(
   parameter int                NUM_EP  = 4,
   parameter logic [NUM_EP-1:0] HB_MASK = '0
) (
   input  logic                  phy_clk,
   input  logic                  reset,
   input  logic [NUM_EP-1:0]     act,
   input  logic [NUM_EP-1:0]     toggle_clr,
   input  logic [NUM_EP-1:0]     halt_set,
   input  logic [NUM_EP-1:0]     halt_clr,
   output logic [NUM_EP-1:0][1:0] toggle,
   output logic [NUM_EP-1:0]     halted
);

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge phy_clk) begin
      if (reset) begin
         toggle <= '0;
         halted <= '0;
      end else begin
         for (int e = 0; e < NUM_EP; e++) begin
            if (halt_set[e])      halted[e] <= 1'b1;
            else if (halt_clr[e]) halted[e] <= 1'b0;

            if (toggle_clr[e] || halt_clr[e]) toggle[e] <= 2'd0;
            else if (act[e])                  toggle[e] <= next_toggle(toggle[e], HB_MASK[e]);
         end
      end
   end

endmodule

// File: rtl/usb2_ep_router.sv
// Routes one transaction at a time between the packet layer and the selected
// endpoint buffer, holding the route until outstanding commit/arm acks return.
module usb2_ep_router
   import usb2_ep_router_pkg::*;
#(
   parameter int                NUM_EP    = 4,
   parameter logic [NUM_EP-1:0] OUT_MASK  = 4'b0101,
   parameter logic [NUM_EP-1:0] IN_MASK   = 4'b0011,
   parameter logic [NUM_EP-1:0] HB_MASK   = 4'b0000,
   parameter int                ADDR_W    = 9,
   parameter int                LEN_W     = 10,
   parameter int                DRAIN_TMO = DRAIN_TMO_DEF
) (
   input  logic                       phy_clk,
   input  logic                       reset,
   input  logic [SEL_W-1:0]           sel_endp,
   input  logic                       sel_valid,
   input  logic                       txn_done,
   output logic                       sel_busy,
   output logic                       sel_nak,
   output logic                       err_bad_endp,
   output logic                       err_timeout,
   usb2_ep_router_if.slave            pkt,
   input  logic                       data_toggle_act,
   output logic [1:0]                 data_toggle,
   input  logic [NUM_EP-1:0]          toggle_clr,
   input  logic [NUM_EP-1:0]          halt_set,
   input  logic [NUM_EP-1:0]          halt_clr,
   output logic [NUM_EP-1:0]          ep_halted,
   output logic [NUM_EP*ADDR_W-1:0]   ep_in_addr,
   output logic [NUM_EP*8-1:0]        ep_in_data,
   output logic [NUM_EP-1:0]          ep_in_wren,
   output logic [NUM_EP-1:0]          ep_in_commit,
   output logic [NUM_EP*LEN_W-1:0]    ep_in_commit_len,
   input  logic [NUM_EP-1:0]          ep_in_ready,
   input  logic [NUM_EP-1:0]          ep_in_commit_ack,
   output logic [NUM_EP*ADDR_W-1:0]   ep_out_addr,
   output logic [NUM_EP-1:0]          ep_out_arm,
   input  logic [NUM_EP*8-1:0]        ep_out_q,
   input  logic [NUM_EP*LEN_W-1:0]    ep_out_len,
   input  logic [NUM_EP-1:0]          ep_out_hasdata,
   input  logic [NUM_EP-1:0]          ep_out_arm_ack
);

   localparam logic [7:0] TMO_CNT = 8'(DRAIN_TMO);

   state_e            state, state_nxt;
   logic [SEL_W-1:0]  cur_ep, cur_ep_nxt;
   logic              commit_pend, commit_pend_nxt, arm_pend, arm_pend_nxt;
   logic [7:0]        cnt, cnt_nxt;
   logic              nak_nxt, bad_nxt, tmo_nxt;

   logic                   active, sel_ok, sel_halted;
   logic [NUM_EP-1:0]      sel_vec, in_en, out_en;
   logic [NUM_EP-1:0][1:0] toggle;
   logic                   in_ready, commit_ack, out_hasdata, arm_ack;
   logic [7:0]             out_q;
   logic [LEN_W-1:0]       out_len;
   logic [1:0]             tog;
   logic                   commit_left, arm_left, outstanding;

   assign active   = (state != ST_IDLE);
   assign sel_busy = active;

   // NOTE: every always_comb output gets a default before any branch, so no
   // path can leave a value held and infer a latch.
   always_comb begin
      sel_vec    = '0;
      sel_ok     = 1'b0;
      sel_halted = 1'b0;
      for (int e = 0; e < NUM_EP; e++) begin
         sel_vec[e] = active && (cur_ep == SEL_W'(e));
         if (sel_endp == SEL_W'(e)) begin
            sel_ok     = IN_MASK[e] | OUT_MASK[e];
            sel_halted = ep_halted[e];
         end
      end
   end

   assign in_en  = sel_vec & OUT_MASK;
   assign out_en = sel_vec & IN_MASK;

   always_comb begin
      ep_in_addr       = '0;
      ep_in_data       = '0;
      ep_in_commit_len = '0;
      ep_out_addr      = '0;
      in_ready         = 1'b0;
      commit_ack       = 1'b0;
      out_q            = '0;
      out_len          = '0;
      out_hasdata      = 1'b0;
      arm_ack          = 1'b0;
      tog              = '0;
      for (int e = 0; e < NUM_EP; e++) begin
         if (in_en[e]) begin
            ep_in_addr[e*ADDR_W +: ADDR_W]     = pkt.buf_in_addr;
            ep_in_data[e*8 +: 8]               = pkt.buf_in_data;
            ep_in_commit_len[e*LEN_W +: LEN_W] = pkt.buf_in_commit_len;
            in_ready   = ep_in_ready[e];
            commit_ack = ep_in_commit_ack[e];
         end
         if (out_en[e]) begin
            ep_out_addr[e*ADDR_W +: ADDR_W] = pkt.buf_out_addr;
            out_q       = ep_out_q[e*8 +: 8];
            out_len     = ep_out_len[e*LEN_W +: LEN_W];
            out_hasdata = ep_out_hasdata[e];
            arm_ack     = ep_out_arm_ack[e];
         end
         if (sel_vec[e]) tog = toggle[e];
      end
   end

   assign ep_in_wren            = in_en  & {NUM_EP{pkt.buf_in_wren}};
   assign ep_in_commit          = in_en  & {NUM_EP{pkt.buf_in_commit}};
   assign ep_out_arm            = out_en & {NUM_EP{pkt.buf_out_arm}};
   assign pkt.buf_in_ready      = in_ready;
   assign pkt.buf_in_commit_ack = commit_ack;
   assign pkt.buf_out_q         = out_q;
   assign pkt.buf_out_len       = out_len;
   assign pkt.buf_out_hasdata   = out_hasdata;
   assign pkt.buf_out_arm_ack   = arm_ack;
   assign data_toggle           = tog;

   // An ack in the same cycle as its request or as txn_done counts as cleared.
   assign commit_left = (commit_pend | (pkt.buf_in_commit & |in_en))  & ~commit_ack;
   assign arm_left    = (arm_pend    | (pkt.buf_out_arm   & |out_en)) & ~arm_ack;
   assign outstanding = commit_left | arm_left;

   always_comb begin
      state_nxt       = state;
      cur_ep_nxt      = cur_ep;
      cnt_nxt         = cnt;
      commit_pend_nxt = commit_left;
      arm_pend_nxt    = arm_left;
      nak_nxt         = 1'b0;
      bad_nxt         = 1'b0;
      tmo_nxt         = 1'b0;
      unique case (state)
         ST_IDLE: begin
            commit_pend_nxt = 1'b0;
            arm_pend_nxt    = 1'b0;
            if (sel_valid) begin
               if (!sel_ok)         bad_nxt = 1'b1;
               else if (sel_halted) nak_nxt = 1'b1;
               else begin
                  cur_ep_nxt = sel_endp;
                  state_nxt  = ST_ACTIVE;
               end
            end
         end
         ST_ACTIVE: begin
            if (txn_done) begin
               state_nxt = outstanding ? ST_DRAIN : ST_IDLE;
               cnt_nxt   = '0;
            end
         end
         ST_DRAIN: begin
            cnt_nxt = cnt + 8'd1;
            if (!outstanding) state_nxt = ST_IDLE;
            else if (cnt_nxt == TMO_CNT) begin
               tmo_nxt   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge phy_clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         cur_ep       <= '0;
         cnt          <= '0;
         commit_pend  <= 1'b0;
         arm_pend     <= 1'b0;
         sel_nak      <= 1'b0;
         err_bad_endp <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         state        <= state_nxt;
         cur_ep       <= cur_ep_nxt;
         cnt          <= cnt_nxt;
         commit_pend  <= commit_pend_nxt;
         arm_pend     <= arm_pend_nxt;
         sel_nak      <= nak_nxt;
         err_bad_endp <= bad_nxt;
         err_timeout  <= tmo_nxt;
      end
   end

   usb2_ep_router_toggle_bank #(
      .NUM_EP  (NUM_EP),
      .HB_MASK (HB_MASK)
   ) u_toggle_bank (
      .phy_clk    (phy_clk),
      .reset      (reset),
      .act        (sel_vec & {NUM_EP{data_toggle_act}}),
      .toggle_clr (toggle_clr),
      .halt_set   (halt_set),
      .halt_clr   (halt_clr),
      .toggle     (toggle),
      .halted     (ep_halted)
   );

endmodule

// File: doc/usb2_ep_router.md
# usb2_ep_router

Parametrised USB 2.0 endpoint router between the packet layer and NUM_EP endpoint buffer blocks (usb2_ep0/usb2_ep instances). It latches one endpoint per transaction, routes the packet-side buffer handshakes to that endpoint only, and waits for outstanding commit/arm acknowledges before releasing. It also owns per-endpoint data-toggle and halt state, and flags accesses to invalid or halted endpoints.

## Interface
- NUM_EP, 4, endpoints routed, 1..16
- OUT_MASK, 4'b0101, bit e set: endpoint e accepts buf_in_* (host-to-device)
- IN_MASK, 4'b0011, bit e set: endpoint e serves buf_out_* (device-to-host)
- HB_MASK, 4'b0000, bit e set: high-bandwidth toggle sequence 0,1,2
- ADDR_W, 9, buffer address width
- LEN_W, 10, packet length width
- DRAIN_TMO, 255, max cycles waiting for ack in DRAIN

Ports:
- phy_clk  in  1  the only clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- sel_endp  in  4  endpoint number for the next transaction
- sel_valid  in  1  one-cycle pulse: start transaction on sel_endp
- txn_done  in  1  one-cycle pulse: packet layer finished transaction
- sel_busy  out  1  high in ACTIVE and DRAIN
- sel_nak  out  1  pulse: selected endpoint halted
- err_bad_endp  out  1  pulse: sel_endp >= NUM_EP or not in IN_MASK|OUT_MASK
- err_timeout  out  1  pulse: DRAIN_TMO expired
- buf_in_addr/data/wren/commit/commit_len  in  ADDR_W/8/1/1/LEN_W  packet-side write path
- buf_in_ready, buf_in_commit_ack  out  1  from current endpoint
- buf_out_addr, buf_out_arm  in  ADDR_W/1  packet-side read path
- buf_out_q/len/hasdata/arm_ack  out  8/LEN_W/1/1  from current endpoint
- data_toggle_act  in  1  advance toggle of current endpoint
- data_toggle  out  2  toggle of current endpoint
- toggle_clr, halt_set, halt_clr  in  NUM_EP  per-endpoint pulses
- ep_halted  out  NUM_EP  halt state
- ep_* flattened buses  in/out  NUM_EP×width  endpoint side of every buffer signal above

## Operation
- FSM states: IDLE, ACTIVE, DRAIN.
- IDLE: all ep_* drive outputs are 0 and packet-side outputs are 0.
  - sel_valid with an invalid endpoint: pulse err_bad_endp and stay in IDLE.
  - sel_valid with a halted endpoint: pulse sel_nak and stay in IDLE.
  - sel_valid otherwise: latch cur_ep and go to ACTIVE.
- ACTIVE: combinational routing to/from cur_ep only; other endpoints see zeros. buf_in_* is routed only if OUT_MASK[cur_ep]; buf_out_* only if IN_MASK[cur_ep]; a masked direction reads 0.
- Outstanding flag: set on commit or arm, cleared on the matching ack.
- txn_done in ACTIVE: go to IDLE if nothing is outstanding, else DRAIN. txn_done in the same cycle as an ack counts as cleared.
- DRAIN: routing held; go to IDLE on ack. On timeout, pulse err_timeout and go to IDLE.
- sel_valid outside IDLE is ignored.
- Toggle: 2 bits per endpoint. act advances 0→1→0, or 0→1→2→0 when HB_MASK is set.
  - toggle_clr or halt_clr zeroes the toggle; a clear wins over act in the same cycle.
- Halt: halt_set wins over halt_clr when both arrive in the same cycle. Halting cur_ep mid-transaction does not abort it.

## Timing
- Reset values: state IDLE, cur_ep 0, toggles 0, ep_halted 0, all pulse and ack outputs 0.
- Reset mid-transaction forces IDLE on the next edge; outstanding flags are cleared.
- sel_valid at edge N gives ACTIVE and routing live from cycle N+1. Routing paths are combinational (0 latency).
- err_bad_endp and sel_nak assert in cycle N+1 for one cycle.
- DRAIN timeout counter is 8 bits: it starts at 0 on DRAIN entry and fires when it reaches DRAIN_TMO.
- Toggle update is visible on data_toggle the cycle after act.

## Structure
- Shared package/include usb2_router_defs.vh: state encodings, SEL width (4), DRAIN_TMO default.
- Sub-module usb2_toggle_bank: per-endpoint toggle and halt registers, HB wrap logic, clear priority.
- The top module contains the FSM, the outstanding flags and the mux/demux.

## Test plan
- Reset, then sel_valid ep1 (IN), arm → arm_ack after 3 cycles, txn_done: buf_out_q equals ep1 data; ACTIVE→IDLE; other ep arm stays 0.
- sel_valid ep2 (OUT), commit, txn_done before commit_ack, which arrives 5 cycles later: DRAIN for 5 cycles, then IDLE; sel_busy high throughout.
- sel_endp=7 with NUM_EP=4: err_bad_endp pulses 1 cycle; state IDLE; no ep_* activity.
- halt_set[1], sel ep1: sel_nak pulses. halt_clr[1] after three acts: toggle returns 0 and next sel ep1 enters ACTIVE.
- HB_MASK[2]=1, four acts: data_toggle 1,2,0,1. act plus toggle_clr in the same cycle: 0.
- commit with no ack, txn_done: err_timeout exactly 255 cycles after DRAIN entry. Reset asserted mid-ACTIVE: IDLE next cycle, all outputs 0.
